// File: rtl/mux_nby1_scan.sv
// N-channel registered multiplexer with manual select and auto-scan modes.
// Scan mode rotates through channels, holding each for DWELL cycles.
module mux_nby1_scan #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_CH  = 4,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  mode,
    input  logic                  en,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  sel_err
);
    localparam int unsigned CNT_W  = $clog2(DWELL) + 1;
    localparam int unsigned N_SLOT = 1 << SEL_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);
    localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W + 1)'(N_CH);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] chan [N_SLOT];
    logic [CNT_W-1:0] cnt_base_c;
    logic             cnt_wrap_c;
    logic [SEL_W-1:0] scan_sel_c;
    logic             sel_ok_c;

    // Unpack channels into a full select-space array; unused slots read as zero
    always_comb begin
        for (int unsigned k = 0; k < N_SLOT; k++) begin
            chan[k] = '0;
        end
        for (int unsigned k = 0; k < N_CH; k++) begin
            chan[k] = in_bus[k*WIDTH +: WIDTH];
        end
    end

    // Next scan position; coming from manual the dwell restarts at zero
    always_comb begin
        cnt_base_c = (state == MANUAL) ? '0 : cnt;
        cnt_wrap_c = (cnt_base_c == CNT_LAST);
        scan_sel_c = cur_sel;
        if (cnt_wrap_c) begin
            scan_sel_c = (cur_sel == SEL_LAST) ? '0 : cur_sel + SEL_W'(1);
        end
        sel_ok_c = ({1'b0, sel} < N_CH_EXT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            cur_sel   <= '0;
            sel_err   <= 1'b0;
        end else if (!en) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else if (!mode) begin
            state <= MANUAL;
            cnt   <= '0;
            if (sel_ok_c) begin
                out       <= chan[sel];
                cur_sel   <= sel;
                out_valid <= 1'b1;
                sel_err   <= 1'b0;
            end else begin
                out_valid <= 1'b0;
                sel_err   <= 1'b1;
            end
        end else begin
            state     <= SCAN;
            cnt       <= cnt_wrap_c ? '0 : cnt_base_c + CNT_W'(1);
            cur_sel   <= scan_sel_c;
            out       <= chan[scan_sel_c];
            out_valid <= 1'b1;
            sel_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nby1_scan.sv
// Scoreboard bench for mux_nby1_scan: a 4-channel/DWELL=4 instance and a
// 3-channel/DWELL=1 instance share stimulus and are checked against a model.
module tb_mux_nby1_scan;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] in_bus;
    logic [1:0]  sel;
    logic        mode;
    logic        en;
    logic [7:0]  out_a, out_b;
    logic        vld_a, vld_b, err_a, err_b;
    logic [1:0]  cs_a, cs_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_nby1_scan #(.WIDTH(8), .N_CH(4), .SEL_W(2), .DWELL(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .sel(sel), .mode(mode), .en(en),
        .out(out_a), .out_valid(vld_a), .cur_sel(cs_a), .sel_err(err_a)
    );

    mux_nby1_scan #(.WIDTH(8), .N_CH(3), .SEL_W(2), .DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus[23:0]), .sel(sel), .mode(mode), .en(en),
        .out(out_b), .out_valid(vld_b), .cur_sel(cs_b), .sel_err(err_b)
    );

    // Model view: which channel is shown, how many scan cycles it has been shown
    typedef struct {
        bit         manual;
        int         spent;
        int         cur;
        logic [7:0] out;
        bit         vld;
        bit         err;
    } model_t;

    localparam model_t RST = '{manual: 1'b0, spent: 0, cur: 0, out: 8'h00, vld: 1'b0, err: 1'b0};

    model_t ma = RST;
    model_t mb = RST;
    model_t ea, eb;
    model_t qa[$];
    model_t qb[$];

    function automatic model_t step(model_t m, int n_ch, int dwell, bit rst, bit e, bit md,
                                    int s, logic [31:0] bus);
        model_t r;
        int     spent;
        r = m;
        if (rst) return RST;
        if (!e) begin
            r.manual = 1'b0;
            r.vld    = 1'b0;
            return r;
        end
        if (!md) begin
            r.manual = 1'b1;
            r.spent  = 0;
            if (s < n_ch) begin
                r.cur = s;
                r.out = bus[s*8 +: 8];
                r.vld = 1'b1;
                r.err = 1'b0;
            end else begin
                r.vld = 1'b0;
                r.err = 1'b1;
            end
            return r;
        end
        spent = m.manual ? 1 : m.spent + 1;
        if (spent >= dwell) begin
            spent = 0;
            r.cur = (m.cur + 1) % n_ch;
        end
        r.manual = 1'b0;
        r.spent  = spent;
        r.out    = bus[r.cur*8 +: 8];
        r.vld    = 1'b1;
        r.err    = 1'b0;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input model_t a, input model_t b);
        chk("a_out", int'(out_a), int'(a.out));
        chk("a_valid", int'(vld_a), int'(a.vld));
        chk("a_cur_sel", int'(cs_a), a.cur);
        chk("a_sel_err", int'(err_a), int'(a.err));
        chk("b_out", int'(out_b), int'(b.out));
        chk("b_valid", int'(vld_b), int'(b.vld));
        chk("b_cur_sel", int'(cs_b), b.cur);
        chk("b_sel_err", int'(err_b), int'(b.err));
    endtask

    // Monitor: one expected entry per clock, compared away from the active edge
    always @(negedge clk) begin
        if (qa.size() != 0 && qb.size() != 0) begin
            ea = qa.pop_front();
            eb = qb.pop_front();
            chk_all(ea, eb);
        end
    end

    task automatic cyc(input bit e, input bit md, input int s);
        en   = e;
        mode = md;
        sel  = 2'(s);
        @(posedge clk);
        ma = step(ma, 4, 4, !rst_n, en, mode, int'(sel), in_bus);
        mb = step(mb, 3, 1, !rst_n, en, mode, int'(sel), in_bus);
        qa.push_back(ma);
        qb.push_back(mb);
        #1;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        ma = RST;
        mb = RST;
        chk_all(ma, mb);
        cyc(1'b0, 1'b0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        in_bus = 32'h0;
        sel    = 2'd0;
        mode   = 1'b0;
        en     = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_all(ma, mb);
        cyc(1'b0, 1'b0, 0);
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, 1'b0, 0);

        // Manual selection and data follow-through
        in_bus = 32'hDDCCBBAA;
        cyc(1'b1, 1'b0, 2);
        cyc(1'b1, 1'b0, 0);
        in_bus[7:0] = 8'h11;
        cyc(1'b1, 1'b0, 0);
        cyc(1'b1, 1'b0, 0);

        // Asynchronous reset with non-zero outputs
        async_reset();
        repeat (2) cyc(1'b0, 1'b0, 0);

        // Illegal select on the 3-channel instance holds out/cur_sel
        in_bus = 32'hDDCCBBAA;
        cyc(1'b1, 1'b0, 1);
        cyc(1'b1, 1'b0, 3);
        cyc(1'b1, 1'b0, 3);
        cyc(1'b1, 1'b0, 1);

        // Scan from reset
        async_reset();
        repeat (17) cyc(1'b1, 1'b1, 0);

        // Freeze mid-dwell, then resume from the frozen count
        for (int i = 0; i < 8 && ma.spent != 2; i++) cyc(1'b1, 1'b1, 0);
        repeat (5) cyc(1'b0, 1'b1, 0);
        repeat (6) cyc(1'b1, 1'b1, 0);

        // Manual to scan and back
        cyc(1'b1, 1'b0, 3);
        repeat (6) cyc(1'b1, 1'b1, 0);
        cyc(1'b1, 1'b0, 1);
        cyc(1'b1, 1'b0, 1);

        // Reset while scanning
        repeat (3) cyc(1'b1, 1'b1, 0);
        async_reset();

        // Randomized traffic
        mode = 1'b0;
        for (int i = 0; i < 800; i++) begin
            int  r;
            bit  e;
            bit  md;
            r  = int'($urandom_range(0, 99));
            md = mode;
            if (r < 2) async_reset();
            if (r < 10) in_bus = $urandom;
            if ($urandom_range(0, 99) < 12) md = ~md;
            e = ($urandom_range(0, 9) != 0);
            cyc(e, md, int'($urandom_range(0, 3)));
        end

        cyc(1'b0, 1'b0, 0);
        @(negedge clk);
        #1;
        if (qa.size() != 0) chk("queue_drain", qa.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
